// File: rtl/exc_entry_seq_pkg.sv
// Shared fault codes, MSR bit definitions, SPR selects and vector offsets
// for the exception-entry engine.
package exc_entry_seq_pkg;

  typedef enum logic [3:0] {
    FC_NONE      = 4'd0,
    FC_IRQ       = 4'd1,
    FC_DEC       = 4'd2,
    FC_FP        = 4'd3,
    FC_PROG_ILL  = 4'd4,
    FC_PRIV      = 4'd5,
    FC_TRAP      = 4'd6,
    FC_SC        = 4'd7,
    FC_ISI_TF    = 4'd8,
    FC_ISI_PF    = 4'd9,
    FC_ISI_NX    = 4'd10,
    FC_MEM_ALIGN = 4'd11,
    // DSI codes carry the W (bit 1) and P (bit 0) qualifiers in the code itself
    FC_DSI       = 4'd12,
    FC_DSI_P     = 4'd13,
    FC_DSI_W     = 4'd14,
    FC_DSI_WP    = 4'd15
  } fc_e;

  localparam logic [31:0] MSR_EE = 32'h0000_8000;
  localparam logic [31:0] MSR_IP = 32'h0000_0040;

  localparam logic [1:0] SPR_SRR0  = 2'd0;
  localparam logic [1:0] SPR_SRR1  = 2'd1;
  localparam logic [1:0] SPR_DSISR = 2'd2;
  localparam logic [1:0] SPR_DAR   = 2'd3;

  localparam logic [15:0] VEC_DSI   = 16'h0300;
  localparam logic [15:0] VEC_ISI   = 16'h0400;
  localparam logic [15:0] VEC_IRQ   = 16'h0500;
  localparam logic [15:0] VEC_ALIGN = 16'h0600;
  localparam logic [15:0] VEC_PROG  = 16'h0700;
  localparam logic [15:0] VEC_FP    = 16'h0800;
  localparam logic [15:0] VEC_DEC   = 16'h0900;
  localparam logic [15:0] VEC_SC    = 16'h0C00;

  // Bit n set: fault code n is recognised / is gated by MSR_EE.
  localparam logic [15:0] FC_KNOWN_MASK = 16'hFFFE;
  localparam logic [15:0] FC_EE_MASK    = 16'h0006;

  function automatic logic fc_eligible(input logic [3:0] fc, input logic [31:0] msr);
    return FC_KNOWN_MASK[fc] && (!FC_EE_MASK[fc] || ((msr & MSR_EE) != 32'h0));
  endfunction

endpackage

// File: rtl/exc_entry_seq_if.sv
// Fault request channels, SPR write port and fetch redirect port of the
// exception-entry engine; master is the engine, slave its environment.
interface exc_entry_seq_if #(
  parameter int REGSZ = 32,
  parameter int NSRC  = 4
);
  logic [NSRC-1:0]       req_valid;
  logic [4*NSRC-1:0]     req_fault;
  logic [REGSZ*NSRC-1:0] req_pc;
  logic [32*NSRC-1:0]    req_instr;
  logic [REGSZ*NSRC-1:0] req_addr;
  logic [NSRC-1:0]       req_ack;
  logic [31:0]           msr;
  logic                  spr_wr_en;
  logic [1:0]            spr_wr_sel;
  logic [REGSZ-1:0]      spr_wr_data;
  logic                  spr_wr_ready;
  logic                  redir_valid;
  logic [REGSZ-1:0]      redir_pc;
  logic [31:0]           redir_msr;
  logic                  redir_ready;
  logic                  busy;

  modport master (
    input  req_valid, req_fault, req_pc, req_instr, req_addr, msr,
           spr_wr_ready, redir_ready,
    output req_ack, spr_wr_en, spr_wr_sel, spr_wr_data,
           redir_valid, redir_pc, redir_msr, busy
  );

  modport slave (
    output req_valid, req_fault, req_pc, req_instr, req_addr, msr,
           spr_wr_ready, redir_ready,
    input  req_ack, spr_wr_en, spr_wr_sel, spr_wr_data,
           redir_valid, redir_pc, redir_msr, busy
  );
endinterface

// File: rtl/exc_vector_calc.sv
// Combinational map from (fault, instr, pc, msr) to the SRR0/SRR1/DSISR
// values, the vector PC and whether a DAR write follows.
module exc_vector_calc
  import exc_entry_seq_pkg::*;
#(
  parameter int REGSZ = 32
) (
  input  logic [3:0]       fault,
  input  logic [31:0]      instr,
  input  logic [REGSZ-1:0] pc,
  input  logic [31:0]      msr,
  output logic [REGSZ-1:0] srr0,
  output logic [31:0]      srr1,
  output logic [REGSZ-1:0] vector,
  output logic [31:0]      dsisr,
  output logic             needs_dar
);

  // Everything above bit 19 is set when vectors are relocated high.
  localparam logic [REGSZ-1:0] HI_BASE = ~REGSZ'(20'hF_FFFF);

  logic [15:0] offset;
  logic [6:0]  f7;
  logic [31:0] msr_lo;
  logic        unused_instr;

  assign f7 = instr[31] ? {2'b00, instr[26], instr[30:27]}
                        : {instr[2:1], instr[6], instr[10:7]};
  assign msr_lo = msr & 32'h0000_FFFF;
  assign unused_instr = ^{instr[15:11], instr[5:3], instr[0]};

  always_comb begin
    offset    = 16'h0;
    srr0      = pc;
    srr1      = 32'h0;
    dsisr     = 32'h0;
    needs_dar = 1'b0;
    case (fc_e'(fault))
      FC_IRQ:      begin offset = VEC_IRQ;  srr1 = msr; end
      FC_DEC:      begin offset = VEC_DEC;  srr1 = msr; end
      FC_FP:       begin offset = VEC_FP;   srr1 = msr; end
      FC_PROG_ILL: begin offset = VEC_PROG; srr1 = (msr & 32'h8000_FFFF) | 32'h0008_0000; end
      FC_PRIV:     begin offset = VEC_PROG; srr1 = (msr & 32'h8000_FFFF) | 32'h0004_0000; end
      FC_TRAP:     begin offset = VEC_PROG; srr1 = (msr & 32'h8000_FFFF) | 32'h0002_0000; end
      FC_SC:       begin offset = VEC_SC;   srr1 = msr_lo; srr0 = pc + REGSZ'(4); end
      FC_ISI_TF:   begin offset = VEC_ISI;  srr1 = (msr & 32'h07FF_FFFF) | 32'h4000_0000; end
      FC_ISI_PF:   begin offset = VEC_ISI;  srr1 = (msr & 32'h07FF_FFFF) | 32'h0800_0000; end
      FC_ISI_NX:   begin offset = VEC_ISI;  srr1 = (msr & 32'h07FF_FFFF) | 32'h1000_0000; end
      FC_MEM_ALIGN: begin
        offset    = VEC_ALIGN;
        srr1      = msr_lo;
        dsisr     = {15'b0, f7, instr[25:21], instr[20:16]};
        needs_dar = 1'b1;
      end
      FC_DSI, FC_DSI_P, FC_DSI_W, FC_DSI_WP: begin
        offset    = VEC_DSI;
        srr1      = msr_lo;
        dsisr     = (fault[1] ? 32'h0200_0000 : 32'h0)
                  | (fault[0] ? 32'h0800_0000 : 32'h4000_0000);
        needs_dar = 1'b1;
      end
      default: ;
    endcase
  end

  assign vector = (((msr & MSR_IP) != 32'h0) ? HI_BASE : '0) | REGSZ'(offset);

endmodule

// File: rtl/exc_entry_seq.sv
// Exception-entry engine: priority arbiter over NSRC fault channels, fault
// latch, then SRR0/SRR1[/DSISR/DAR] SPR writes and one fetch redirect.
module exc_entry_seq
  import exc_entry_seq_pkg::*;
#(
  parameter int REGSZ = 32,
  parameter int NSRC  = 4
) (
  input logic              clk,
  input logic              reset,
  exc_entry_seq_if.master  bus
);

  localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SRR0  = 3'd1;
  localparam logic [2:0] S_SRR1  = 3'd2;
  localparam logic [2:0] S_DSISR = 3'd3;
  localparam logic [2:0] S_DAR   = 3'd4;
  localparam logic [2:0] S_REDIR = 3'd5;

  logic [2:0]       state;
  logic             found;
  logic [IDXW-1:0]  win;
  logic             idle;

  logic [3:0]       w_fault;
  logic [31:0]      w_instr;
  logic [REGSZ-1:0] w_pc;
  logic [REGSZ-1:0] c_srr0;
  logic [31:0]      c_srr1;
  logic [REGSZ-1:0] c_vector;
  logic [31:0]      c_dsisr;
  logic             c_needs_dar;

  logic [31:0]      srr1_q;
  logic [31:0]      dsisr_q;
  logic [REGSZ-1:0] dar_q;
  logic [REGSZ-1:0] vec_q;
  logic [31:0]      nmsr_q;
  logic             dar_en_q;

  logic             spr_en_q;
  logic [1:0]       spr_sel_q;
  logic [REGSZ-1:0] spr_data_q;
  logic             redir_vld_q;
  logic [REGSZ-1:0] redir_pc_q;
  logic [31:0]      redir_msr_q;

  logic             spr_hs;
  logic             redir_hs;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && bus.req_valid[i] && fc_eligible(bus.req_fault[4*i +: 4], bus.msr)) begin
        found = 1'b1;
        win   = IDXW'(i);
      end
    end
  end

  assign w_fault = bus.req_fault[4*win +: 4];
  assign w_instr = bus.req_instr[32*win +: 32];
  assign w_pc    = bus.req_pc[REGSZ*win +: REGSZ];

  exc_vector_calc #(.REGSZ(REGSZ)) u_calc (
    .fault     (w_fault),
    .instr     (w_instr),
    .pc        (w_pc),
    .msr       (bus.msr),
    .srr0      (c_srr0),
    .srr1      (c_srr1),
    .vector    (c_vector),
    .dsisr     (c_dsisr),
    .needs_dar (c_needs_dar)
  );

  assign idle     = (state == S_IDLE);
  assign spr_hs   = spr_en_q & bus.spr_wr_ready;
  assign redir_hs = redir_vld_q & bus.redir_ready;

  // Ack is qualified by reset so every output reads 0 while reset is held.
  assign bus.req_ack     = (idle && found && reset) ? (NSRC'(1) << win) : '0;
  assign bus.busy        = !idle;
  assign bus.spr_wr_en   = spr_en_q;
  assign bus.spr_wr_sel  = spr_sel_q;
  assign bus.spr_wr_data = spr_data_q;
  assign bus.redir_valid = redir_vld_q;
  assign bus.redir_pc    = redir_pc_q;
  assign bus.redir_msr   = redir_msr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      srr1_q      <= '0;
      dsisr_q     <= '0;
      dar_q       <= '0;
      vec_q       <= '0;
      nmsr_q      <= '0;
      dar_en_q    <= 1'b0;
      spr_en_q    <= 1'b0;
      spr_sel_q   <= '0;
      spr_data_q  <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      redir_msr_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          srr1_q     <= c_srr1;
          dsisr_q    <= c_dsisr;
          dar_q      <= bus.req_addr[REGSZ*win +: REGSZ];
          vec_q      <= c_vector;
          nmsr_q     <= bus.msr & MSR_IP;
          dar_en_q   <= c_needs_dar;
          spr_en_q   <= 1'b1;
          spr_sel_q  <= SPR_SRR0;
          spr_data_q <= c_srr0;
          state      <= S_SRR0;
        end
        S_SRR0: if (spr_hs) begin
          spr_sel_q  <= SPR_SRR1;
          spr_data_q <= REGSZ'(srr1_q);
          state      <= S_SRR1;
        end
        S_SRR1: if (spr_hs) begin
          if (dar_en_q) begin
            spr_sel_q  <= SPR_DSISR;
            spr_data_q <= REGSZ'(dsisr_q);
            state      <= S_DSISR;
          end else begin
            spr_en_q    <= 1'b0;
            redir_vld_q <= 1'b1;
            redir_pc_q  <= vec_q;
            redir_msr_q <= nmsr_q;
            state       <= S_REDIR;
          end
        end
        S_DSISR: if (spr_hs) begin
          spr_sel_q  <= SPR_DAR;
          spr_data_q <= dar_q;
          state      <= S_DAR;
        end
        S_DAR: if (spr_hs) begin
          spr_en_q    <= 1'b0;
          redir_vld_q <= 1'b1;
          redir_pc_q  <= vec_q;
          redir_msr_q <= nmsr_q;
          state       <= S_REDIR;
        end
        S_REDIR: if (redir_hs) begin
          redir_vld_q <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_entry_seq.sv
// Randomised and directed bench for exc_entry_seq against a table-driven
// transaction model of the exception-entry rules.
module tb_exc_entry_seq;

  localparam int REGSZ = 32;
  localparam int NSRC  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_entry_seq_if #(.REGSZ(REGSZ), .NSRC(NSRC)) bus ();
  exc_entry_seq #(.REGSZ(REGSZ), .NSRC(NSRC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-code vector offset, SRR1 keep mask and SRR1 set bits.
  localparam logic [15:0] OFF_T [16] = '{16'h0, 16'h500, 16'h900, 16'h800, 16'h700, 16'h700,
                                          16'h700, 16'hC00, 16'h400, 16'h400, 16'h400, 16'h600,
                                          16'h300, 16'h300, 16'h300, 16'h300};
  localparam logic [31:0] KEEP_T [16] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                           32'h8000FFFF, 32'h8000FFFF, 32'h8000FFFF, 32'h0000FFFF,
                                           32'h07FFFFFF, 32'h07FFFFFF, 32'h07FFFFFF, 32'h0000FFFF,
                                           32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF};
  localparam logic [31:0] SET_T [16] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h00080000, 32'h00040000,
                                          32'h00020000, 32'h0, 32'h40000000, 32'h08000000,
                                          32'h10000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  logic        ch_valid [NSRC];
  logic [3:0]  ch_fault [NSRC];
  logic [31:0] ch_pc    [NSRC];
  logic [31:0] ch_instr [NSRC];
  logic [31:0] ch_addr  [NSRC];
  logic [31:0] cur_msr;

  task automatic drive();
    for (int i = 0; i < NSRC; i++) begin
      bus.req_valid[i]          = ch_valid[i];
      bus.req_fault[4*i +: 4]   = ch_fault[i];
      bus.req_pc[32*i +: 32]    = ch_pc[i];
      bus.req_instr[32*i +: 32] = ch_instr[i];
      bus.req_addr[32*i +: 32]  = ch_addr[i];
    end
    bus.msr = cur_msr;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NSRC; i++) begin
      ch_valid[i] = 1'b0; ch_fault[i] = 4'd0; ch_pc[i] = 32'h0;
      ch_instr[i] = 32'h0; ch_addr[i] = 32'h0;
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < NSRC; i++)
      if (ch_valid[i] && ch_fault[i] != 4'd0 &&
          ((ch_fault[i] != 4'd1 && ch_fault[i] != 4'd2) || cur_msr[15]))
        return i;
    return -1;
  endfunction

  function automatic void model(input logic [3:0] fc, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] ad, input logic [31:0] ms, output int nb,
                                output logic [3:0][31:0] dat, output logic [31:0] vpc,
                                output logic [31:0] nmsr);
    logic [6:0] f7;
    dat[0] = pc + ((fc == 4'd7) ? 32'd4 : 32'd0);
    dat[1] = (ms & KEEP_T[fc]) | SET_T[fc];
    nb = (fc >= 4'd11) ? 4 : 2;
    f7 = ins[31] ? {2'b00, ins[26], ins[30:27]} : {ins[2:1], ins[6], ins[10:7]};
    if (fc == 4'd11) dat[2] = {15'b0, f7, ins[25:16]};
    else dat[2] = (fc[1] ? 32'h02000000 : 32'h0) | (fc[0] ? 32'h08000000 : 32'h40000000);
    dat[3] = ad;
    vpc  = {16'h0, OFF_T[fc]} | (ms[6] ? 32'hFFF00000 : 32'h0);
    nmsr = ms & 32'h40;
  endfunction

  task automatic run_one(input int smin, input int smax);
    int ch, nb, st;
    logic [3:0][31:0] dat;
    logic [31:0] vpc, nmsr, saved_msr;
    @(negedge clk);
    drive();
    #1;
    ch = pick();
    if (ch < 0) begin
      check("ack_none", bus.req_ack, 0);
      check("busy_none", bus.busy, 0);
      return;
    end
    check("ack", bus.req_ack, 64'd1 << ch);
    check("busy_pre", bus.busy, 0);
    model(ch_fault[ch], ch_pc[ch], ch_instr[ch], ch_addr[ch], cur_msr, nb, dat, vpc, nmsr);
    bus.spr_wr_ready = 1'b0;
    bus.redir_ready  = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", bus.req_ack, 0);
    check("busy", bus.busy, 1);
    // Latched values must survive changes to the request side while busy.
    saved_msr = cur_msr;
    ch_valid[ch] = 1'b0;
    ch_pc[ch] = $urandom; ch_instr[ch] = $urandom; ch_addr[ch] = $urandom;
    ch_fault[ch] = 4'($urandom_range(15, 0));
    cur_msr = $urandom;
    drive();
    for (int k = 0; k < nb; k++) begin
      st = $urandom_range(smax, smin);
      check("spr_en", bus.spr_wr_en, 1);
      check("excl", bus.redir_valid, 0);
      check("sel", bus.spr_wr_sel, k);
      check("data", bus.spr_wr_data, dat[k]);
      for (int s = 0; s < st; s++) begin
        @(posedge clk); #1;
        check("stall_en", bus.spr_wr_en, 1);
        check("stall_sel", bus.spr_wr_sel, k);
        check("stall_data", bus.spr_wr_data, dat[k]);
      end
      bus.spr_wr_ready = 1'b1;
      @(posedge clk); #1;
      bus.spr_wr_ready = 1'b0;
    end
    cur_msr = saved_msr;
    drive();
    st = $urandom_range(smax, smin);
    for (int s = 0; s <= st; s++) begin
      check("redir_vld", bus.redir_valid, 1);
      check("excl_r", bus.spr_wr_en, 0);
      check("redir_pc", bus.redir_pc, vpc);
      check("redir_msr", bus.redir_msr, nmsr);
      if (s < st) begin @(posedge clk); #1; end
    end
    bus.redir_ready = 1'b1;
    @(posedge clk); #1;
    bus.redir_ready = 1'b0;
    check("idle_after", bus.busy, 0);
    check("redir_drop", bus.redir_valid, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_en"}, bus.spr_wr_en, 0);
    check({tag, "_rv"}, bus.redir_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ack"}, bus.req_ack, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.spr_wr_ready = 1'b0;
    bus.redir_ready  = 1'b0;
    clear_all();
    cur_msr = 32'h0;
    ch_valid[0] = 1'b1; ch_fault[0] = 4'd7;
    drive();
    #2;
    check_quiet("reset");
    check("reset_sel", bus.spr_wr_sel, 0);
    check("reset_data", bus.spr_wr_data, 0);
    check("reset_rpc", bus.redir_pc, 0);
    check("reset_rmsr", bus.redir_msr, 0);
    clear_all();
    drive();
    @(negedge clk);
    reset = 1'b1;

    // SC on ch0
    clear_all();
    ch_valid[0] = 1'b1; ch_fault[0] = 4'd7; ch_pc[0] = 32'h1000; cur_msr = 32'h9032;
    run_one(0, 0);

    // DSI with W=1, P=1
    clear_all();
    ch_valid[0] = 1'b1; ch_fault[0] = 4'd15; ch_pc[0] = 32'h4444; ch_addr[0] = 32'hDEAD0000;
    cur_msr = 32'h40;
    run_one(0, 1);

    // ch1 PROG_ILL beats ch2 IRQ, then ch2 is taken
    clear_all();
    ch_valid[2] = 1'b1; ch_fault[2] = 4'd1; ch_pc[2] = 32'h3000;
    ch_valid[1] = 1'b1; ch_fault[1] = 4'd4; ch_pc[1] = 32'h2000;
    cur_msr = 32'h8000;
    run_one(0, 0);
    run_one(0, 0);

    // IRQ masked by EE for 10 cycles, then enabled
    clear_all();
    ch_valid[0] = 1'b1; ch_fault[0] = 4'd1; ch_pc[0] = 32'h5000; cur_msr = 32'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); drive(); #1;
      check("masked_ack", bus.req_ack, 0);
      check("masked_busy", bus.busy, 0);
    end
    cur_msr = 32'h8000;
    run_one(0, 0);

    // MEM_ALIGN with 3-cycle stalls on every beat
    clear_all();
    ch_valid[3] = 1'b1; ch_fault[3] = 4'd11; ch_pc[3] = 32'h6000;
    ch_instr[3] = 32'h7C6418AE; ch_addr[3] = 32'h12345679; cur_msr = 32'h8040;
    run_one(3, 3);

    // Reset while in W_SRR1
    clear_all();
    ch_valid[1] = 1'b1; ch_fault[1] = 4'd9; ch_pc[1] = 32'h7000; cur_msr = 32'h0;
    @(negedge clk); drive();
    @(posedge clk); #1;
    bus.spr_wr_ready = 1'b1;
    @(posedge clk); #1;
    bus.spr_wr_ready = 1'b0;
    check("mid_sel", bus.spr_wr_sel, 1);
    reset = 1'b0;
    #1;
    check_quiet("midrst");
    clear_all();
    drive();
    bus.spr_wr_ready = 1'b1;
    bus.redir_ready  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("post_rst_rv", bus.redir_valid, 0);
      check("post_rst_en", bus.spr_wr_en, 0);
    end
    bus.spr_wr_ready = 1'b0;
    bus.redir_ready  = 1'b0;
    ch_valid[2] = 1'b1; ch_fault[2] = 4'd3; ch_pc[2] = 32'h8000; cur_msr = 32'h41;
    run_one(0, 1);

    // Random traffic
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < NSRC; i++) begin
        ch_valid[i] = 1'($urandom_range(1, 0));
        ch_fault[i] = 4'($urandom_range(15, 0));
        ch_pc[i]    = $urandom;
        ch_instr[i] = $urandom;
        ch_addr[i]  = $urandom;
      end
      cur_msr = $urandom;
      run_one(0, 2);
    end

    clear_all();
    @(negedge clk); drive();
    @(posedge clk); #1;
    check("final_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/exc_entry_seq.md
# exc_entry_seq

Sequential exception-entry engine for the writeback stage. It arbitrates among `NSRC` prioritised fault channels and latches the winning fault. It then drives SRR0, SRR1 and, for data-side faults, DSISR and DAR through a handshaked SPR write port, one register per beat. It finishes by issuing a single fetch redirect carrying the vector PC and the new MSR.

## Interface
- `REGSZ`, 32: architectural register / PC width; must be ≥ 20.
- `NSRC`, 4: number of fault channels; index 0 has the highest priority.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NSRC  per-channel fault request.
- `req_fault`  in  4·NSRC  per-channel `FC_*` code from `decode_enums.vh`.
- `req_pc`  in  REGSZ·NSRC  faulting PC.
- `req_instr`  in  32·NSRC  faulting instruction.
- `req_addr`  in  REGSZ·NSRC  data effective address, used for DAR.
- `req_ack`  out  NSRC  one-hot, single-cycle pulse on the accepted channel.
- `msr`  in  32  current MSR, sampled at accept.
- `spr_wr_en`  out  1  SPR write valid.
- `spr_wr_sel`  out  2  0=SRR0, 1=SRR1, 2=DSISR, 3=DAR.
- `spr_wr_data`  out  REGSZ  write data; the 32-bit values are zero-extended.
- `spr_wr_ready`  in  1  SPR write accepted.
- `redir_valid`  out  1  redirect valid.
- `redir_pc`  out  REGSZ  vector PC.
- `redir_msr`  out  32  new MSR.
- `redir_ready`  in  1  redirect accepted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Eligibility.** A channel is eligible when `req_valid` is high and its code is not `FC_NONE` or an unrecognised code.
  - `FC_IRQ` and `FC_DEC` are eligible only when `msr & MSR_EE` is nonzero.
  - Ineligible channels are never acknowledged.
- **Accept.** In IDLE, the lowest-index eligible channel wins.
  - `req_ack` pulses for that channel.
  - The unit latches the fault, pc, instr, addr and msr of that channel, plus its computed values.
- **Vector base.** The upper bits are `{1…1, 4'h0}` when MSR_IP is set, otherwise zero. The low 16 bits are the offset below.
- **Per-class offset and SRR1:**
  - IRQ: offset 0x0500, SRR1 = msr.
  - DEC: offset 0x0900, SRR1 = msr.
  - FP: offset 0x0800, SRR1 = msr.
  - PROG_ILL / PRIV / TRAP: offset 0x0700, SRR1 = (msr & 0x8000ffff) | 0x00080000, 0x00040000 or 0x00020000 respectively.
  - SC: offset 0x0C00, SRR1 = msr & 0xffff, SRR0 = pc + 4 (wraps modulo 2^REGSZ).
  - ISI_TF / PF / NX: offset 0x0400, SRR1 = (msr & 0x07ffffff) | 0x40000000, 0x08000000 or 0x10000000 respectively.
  - DSI: offset 0x0300, SRR1 = msr & 0xffff.
  - MEM_ALIGN: offset 0x0600, SRR1 = msr & 0xffff.
- **SRR0.** Equal to pc for every class except SC.
- **DSISR for DSI:** (W ? 0x02000000 : 0) | (P ? 0x08000000 : 0x40000000).
- **DSISR for MEM_ALIGN:** `{15'b0, f7, instr[25:21], instr[20:16]}`.
  - When instr[31] is 1, f7 = `{2'b00, instr[26], instr[30:27]}`.
  - When instr[31] is 0, f7 = `{instr[2:1], instr[6], instr[10:7]}`.
- **DAR.** Equal to the latched addr; written only for DSI and MEM_ALIGN.
- **New MSR.** `redir_msr` = latched msr & MSR_IP.
- **State machine:** IDLE → W_SRR0 → W_SRR1 → (W_DSISR → W_DAR, data classes only) → REDIR → IDLE.
  - Each W_* state advances on `spr_wr_en & spr_wr_ready`.
  - REDIR advances on `redir_valid & redir_ready`.
- **Isolation.** Request inputs and `msr` are ignored while busy; only latched values are used.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. A reset mid-sequence abandons the sequence: no further writes are made and no redirect is issued.
- **Accept cycle (cycle 0).** `req_ack` is asserted combinationally from the IDLE state and the eligibility logic, and the latch happens on that edge.
  - Cycle 1: `spr_wr_en` is asserted with SRR0.
  - With ready tied high, SRR1 follows in cycle 2 and the redirect in cycle 3 (cycle 5 for data classes).
- **Stalls.** `spr_wr_en`/`sel`/`data` and `redir_*` are registered and stay stable until their handshake completes.
- **Return to IDLE.** The cycle after the redirect handshake is IDLE. A new accept is possible in that cycle, giving a throughput of one exception per 4 cycles minimum.
- **Exclusivity.** `spr_wr_en` and `redir_valid` are never high together.

## Structure
- New `FC_*` eligibility masks, the SPR select encodings and the vector offsets go in `arch_defs.vh` / `decode_enums.vh`.
- The `MSR_EE` and `MSR_IP` definitions are taken from those same shared headers.
- One combinational sub-module, `exc_vector_calc`, maps (fault, instr, pc, msr) to srr0, srr1, vector, dsisr and a needs_dar flag.
- `exc_entry_seq` holds the arbiter, the latches and the FSM.

## Test plan
- SC on ch0, pc=0x1000, msr=0x9032 → SRR0=0x1004, SRR1=0x9032, redir_pc=0x00000C00, redir_msr=0.
- DSI with W=1, P=1, addr=0xDEAD0000, msr=0x40 → SRR1=0x40, DSISR=0x0A000000, DAR=0xDEAD0000, redir_pc=0xFFF00300, redir_msr=0x40.
- Simultaneous requests: ch2 IRQ (EE=1) and ch1 PROG_ILL with msr=0x8000 → ch1 acked, SRR1=0x00088000, redir_pc=0x700; ch2 is accepted after IDLE.
- IRQ with msr=0 held for 10 cycles → no ack and busy=0; raise EE → ack next cycle and redir_pc=0x500.
- MEM_ALIGN with `spr_wr_ready` low for 3 cycles at each beat → `sel`/`data` held stable; the X-form instr 0x7C6418AE yields the correct DSISR; order is SRR0, SRR1, DSISR, DAR.
- Assert `reset` low while in W_SRR1 → all outputs 0 immediately, no redirect ever issued, and a fresh accept works after release.
